i_line_responder: RTL
=====================

# i_line_responder

Memory-side responder for the instruction cache's physical-memory read port. It accepts a cache-line read request (`icache_pmem_read`, `icache_pmem_address`) and fetches the line from the burst memory bus as consecutive 64-bit beats. It assembles those beats into one 256-bit line and returns it with a single-cycle `icache_pmem_resp` pulse. It sits between the i-cache and the memory arbiter/burst memory, and optionally holds the last fetched line so repeat misses are served without a memory access.

## Interface
- `LINE_BITS`, default 256: cache line width; must equal the i-cache line size.
- `BEAT_BITS`, default 64: burst bus data width; `LINE_BITS/BEAT_BITS` is the beat count N (N ≥ 2, power of two).
- `ADDR_WIDTH`, default 32: byte address width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `icache_pmem_read`  in  1  line read request from the i-cache.
- `icache_pmem_address`  in  ADDR_WIDTH  line address.
- `icache_pmem_rdata`  out  LINE_BITS  assembled line.
- `icache_pmem_resp`  out  1  one-cycle completion pulse.
- `burst_read`  out  1  burst read request to memory.
- `burst_address`  out  ADDR_WIDTH  line-aligned burst address.
- `burst_rdata`  in  BEAT_BITS  beat data.
- `burst_resp`  in  1  beat valid; exactly N pulses per burst.

## Operation
- States: IDLE, BURST, RESP.
- IDLE, `icache_pmem_read`=1: latch the address with the low log2(LINE_BITS/8) bits cleared, clear the beat counter, and go to BURST.
- BURST: drive `burst_read`=1 and `burst_address`=the latched address. On each `burst_resp`=1, write `burst_rdata` into slice [k*BEAT_BITS +: BEAT_BITS] and increment k. On the beat where k=N-1, go to RESP.
- Beats fill the line low slice first; beat 0 is bits [63:0].
- RESP: drive `icache_pmem_resp`=1 for exactly one cycle, then return to IDLE.
- A read still high in the next IDLE cycle starts a new transaction. The i-cache must drop `icache_pmem_read` in the cycle after resp unless it is requesting again.
- Request changes after the latch are ignored: address changes mid-burst have no effect. If `icache_pmem_read` deasserts mid-burst, the burst still completes and resp still pulses.
- `burst_resp` outside BURST is ignored; the data bus is don't-care.
- `icache_pmem_rdata` holds the last assembled line at all times. It changes only while beats are being captured in BURST, and is stable and valid throughout RESP.

## Timing
- Reset (async, immediate): state=IDLE, k=0, `burst_read`=0, `icache_pmem_resp`=0, `icache_pmem_rdata`=0, `burst_address`=0, line buffer invalid.
- Reset mid-burst abandons the burst; the memory side must tolerate a dropped `burst_read`.
- Miss latency: read sampled at edge 0 → `burst_read` high from cycle 1. With back-to-back beats at cycles 1..N, resp is in cycle N+1. Minimum N+1 cycles from sample to resp, i.e. 5 for N=4.
- `burst_read` and `icache_pmem_resp` are registered-state decodes with no combinational path from inputs. `burst_read` drops in the cycle after the last beat.

## Configuration
- `I_LINE_BUFFER_EN` defined: add a one-entry line buffer (tag register plus valid bit), loaded with the latched address when a burst completes.
  - In IDLE, a read whose aligned address equals the tag with valid=1 goes directly to RESP.
  - A hit gives 1-cycle latency and no `burst_read` assertion; `icache_pmem_rdata` already holds the line.
  - Valid is cleared only by reset.
- `I_LINE_BUFFER_EN` undefined: every request issues a burst; the tag and valid registers are absent.

## Structure
- Add to the `i_cache_types` package:
  - the beat-count constant `i_line_beats`;
  - the state enum `i_resp_state_t` (IDLE, BURST, RESP).
- Sub-module `i_line_assembler`: beat counter plus slice-write line register, with inputs `clear`, `beat_valid`, `beat_data` and outputs `line`, `last_beat`. The FSM and the buffer live in the top module.

## Test plan
- Reset mid-burst: read 0x0000_0040, reset asserted after beat 1 → `burst_read` drops immediately, no resp. A fresh read then completes normally.
- Basic miss: read address 0x0000_1234 → `burst_address`=0x0000_1220. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → resp in cycle 5 with rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Stalled beats: same request with `burst_resp` gaps of 3 idle cycles → correct line, exactly one resp pulse, `burst_read` held until the 4th beat.
- Request changes mid-burst: address changed to 0x0000_8000 and read dropped after beat 2 → burst completes at 0x0000_1220 and resp still pulses.
- Back-to-back requests: read held high after resp with a new address 0x0000_2000 → second burst starts in the following IDLE cycle.
- With `I_LINE_BUFFER_EN`:
  - repeat read of 0x0000_1230 → resp one cycle after sampling, `burst_read` never asserted;
  - read of 0x0000_1240 → full burst.

Source files
------------

// File: rtl/i_line_responder_pkg.sv
// Shared types and constants for the i-cache line responder (package i_cache_types).
package i_cache_types;

    localparam int I_LINE_BITS  = 256;
    localparam int I_BEAT_BITS  = 64;
    localparam int I_ADDR_WIDTH = 32;

    localparam int i_line_beats = I_LINE_BITS / I_BEAT_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2
    } i_resp_state_t;

    // Number of byte-offset bits inside one cache line.
    function automatic int line_offset_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

endpackage

// File: rtl/i_line_assembler.sv
// Beat counter and slice-write line register; beat k lands in bits [k*BEAT_BITS +: BEAT_BITS].
module i_line_assembler
    import i_cache_types::*;
#(
    parameter int LINE_BITS = I_LINE_BITS,
    parameter int BEAT_BITS = I_BEAT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 beat_valid,
    input  logic [BEAT_BITS-1:0] beat_data,
    output logic [LINE_BITS-1:0] line,
    output logic                 last_beat
);

    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]     r_beat_cnt;
    logic [LINE_BITS-1:0] r_line;

    // The line is never cleared by a new request so it keeps the last assembled line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt <= '0;
            r_line     <= '0;
        end else if (clear) begin
            r_beat_cnt <= '0;
        end else if (beat_valid) begin
            r_line[r_beat_cnt*BEAT_BITS +: BEAT_BITS] <= beat_data;
            r_beat_cnt                                <= r_beat_cnt + CNT_W'(1);
        end
    end

    assign line      = r_line;
    assign last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/i_line_responder.sv
// I-cache line fill responder: one burst of N beats per miss, single-cycle resp pulse.
// Optional one-line buffer enabled by defining I_LINE_BUFFER_EN.
//
// state | meaning
// IDLE  | waiting for icache_pmem_read; latches aligned address on a miss
// BURST | burst_read high, capturing beats into the line register
// RESP  | icache_pmem_resp high for one cycle, line stable on icache_pmem_rdata
module i_line_responder
    import i_cache_types::*;
#(
    parameter int LINE_BITS  = I_LINE_BITS,
    parameter int BEAT_BITS  = I_BEAT_BITS,
    parameter int ADDR_WIDTH = I_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_BITS-1:0]  icache_pmem_rdata,
    output logic                  icache_pmem_resp,
    output logic                  burst_read,
    output logic [ADDR_WIDTH-1:0] burst_address,
    input  logic [BEAT_BITS-1:0]  burst_rdata,
    input  logic                  burst_resp
);

    localparam int OFFSET_BITS = line_offset_bits(LINE_BITS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    i_resp_state_t         r_state;
    i_resp_state_t         w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_aligned;
    logic                  w_latch;
    logic                  w_beat_valid;
    logic                  w_last_beat;
    logic                  w_burst_done;
    logic                  w_hit;
    logic [LINE_BITS-1:0]  w_line;

    assign w_addr_aligned = icache_pmem_address & ALIGN_MASK;
    assign w_beat_valid   = (r_state == BURST) && burst_resp;
    assign w_burst_done   = w_beat_valid && w_last_beat;

    i_line_assembler #(
        .LINE_BITS (LINE_BITS),
        .BEAT_BITS (BEAT_BITS)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_latch),
        .beat_valid (w_beat_valid),
        .beat_data  (burst_rdata),
        .line       (w_line),
        .last_beat  (w_last_beat)
    );

`ifdef I_LINE_BUFFER_EN
    logic [ADDR_WIDTH-1:0] r_tag;
    logic                  r_valid;

    // The line register already holds the tagged line, so a hit needs no data copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag   <= '0;
            r_valid <= 1'b0;
        end else if (w_burst_done) begin
            r_tag   <= r_addr;
            r_valid <= 1'b1;
        end
    end

    assign w_hit = r_valid && (w_addr_aligned == r_tag);
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_addr <= w_addr_aligned;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (icache_pmem_read) begin
                    if (w_hit) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = BURST;
                        w_latch     = 1'b1;
                    end
                end
            end
            BURST: begin
                if (w_burst_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign burst_read        = (r_state == BURST);
    assign icache_pmem_resp  = (r_state == RESP);
    assign burst_address     = r_addr;
    assign icache_pmem_rdata = w_line;

endmodule
